// File: rtl/kernel_load_ctrl.sv
// Kernel FIFO load sequencer; optional DRAIN timeout / empty checks under KLC_ERR_CHECK_EN.
// Latency: 15 cycles per kernel with immediate ack; first kernel_valid 14 cycles after start.
// Backpressure: holds kernel_valid until kernel_ack; DRAIN stalls until fifo_full.
module kernel_load_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TAPS    = 9,
  parameter int CNT_W   = 8,
  parameter int TMO_CYC = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_kernels,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  kernel_idx,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fifo_clr_n,
  output logic              fifo_write,
  output logic              fifo_read,
  output logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  output logic              kernel_valid,
  input  logic              kernel_ack,
  output logic              error
);
  localparam int TAP_W = $clog2(TAPS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_DRAIN, S_LATCH, S_PRESENT, S_NEXT
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] kbase, kbase_nxt;
  logic [CNT_W-1:0]  nk, nk_nxt, kidx, kidx_nxt;
  logic [CNT_W:0]    kidx_inc;
  logic [TAP_W-1:0]  tap, tap_nxt;
  logic              busy_q, busy_nxt, done_q, done_nxt, wr_q, err_q;

`ifdef KLC_ERR_CHECK_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0]  tmo, tmo_nxt;
  logic              err_nxt, violation;
`endif

  // kbase tracks tap 0 of the current kernel; wraps modulo 2^ADDR_W
  assign kidx_inc     = {1'b0, kidx} + (CNT_W+1)'(1);
  assign mem_rd_en    = (state == S_FETCH);
  assign mem_addr     = mem_rd_en ? kbase + ADDR_W'(tap) : '0;
  assign fifo_write   = wr_q;
  assign fifo_data    = wr_q ? mem_rdata : '0;
  assign fifo_read    = (state == S_LATCH);
  assign kernel_valid = (state == S_PRESENT);
  assign fifo_clr_n   = resetn & (state != S_CLEAR);
  assign busy         = busy_q;
  assign done         = done_q;
  assign kernel_idx   = kidx;
  assign error        = err_q;

  always_comb begin
    state_nxt = state;
    kbase_nxt = kbase;
    nk_nxt    = nk;
    kidx_nxt  = kidx;
    tap_nxt   = tap;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
`ifdef KLC_ERR_CHECK_EN
    tmo_nxt   = tmo;
    err_nxt   = err_q;
    violation = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (start && !err_q) begin
          if (num_kernels != '0) begin
            kbase_nxt = base_addr;
            nk_nxt    = num_kernels;
            kidx_nxt  = '0;
            busy_nxt  = 1'b1;
            state_nxt = S_CLEAR;
          end else begin
            done_nxt  = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        tap_nxt   = '0;
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        tap_nxt = tap + TAP_W'(1);
        if (tap == TAP_W'(TAPS - 1)) state_nxt = S_DRAIN;
`ifdef KLC_ERR_CHECK_EN
        tmo_nxt = '0;
        if (tap == '0 && !fifo_empty) violation = 1'b1;
`endif
      end
      S_DRAIN: begin
        if (fifo_full) state_nxt = S_LATCH;
`ifdef KLC_ERR_CHECK_EN
        else if (tmo == TMO_W'(TMO_CYC - 1)) violation = 1'b1;
        else tmo_nxt = tmo + TMO_W'(1);
`endif
      end
      S_LATCH:   state_nxt = S_PRESENT;
      S_PRESENT: if (kernel_ack) state_nxt = S_NEXT;
      S_NEXT: begin
        if (kidx_inc < {1'b0, nk}) begin
          kidx_nxt  = kidx_inc[CNT_W-1:0];
          kbase_nxt = kbase + ADDR_W'(TAPS);
          state_nxt = S_CLEAR;
        end else begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
`ifdef KLC_ERR_CHECK_EN
    // abort the job without latching; error stays set until resetn
    if (violation) begin
      err_nxt   = 1'b1;
      done_nxt  = 1'b1;
      busy_nxt  = 1'b0;
      state_nxt = S_IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= S_IDLE;
      kbase  <= '0;
      nk     <= '0;
      kidx   <= '0;
      tap    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      wr_q   <= 1'b0;
`ifdef KLC_ERR_CHECK_EN
      tmo    <= '0;
      err_q  <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      kbase  <= kbase_nxt;
      nk     <= nk_nxt;
      kidx   <= kidx_nxt;
      tap    <= tap_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      wr_q   <= mem_rd_en;
`ifdef KLC_ERR_CHECK_EN
      tmo    <= tmo_nxt;
      err_q  <= err_nxt;
`endif
    end
  end

`ifndef KLC_ERR_CHECK_EN
  logic unused_chk;
  assign err_q      = 1'b0;
  assign unused_chk = fifo_empty ^ (TMO_CYC < 0);
`endif

endmodule

// File: tb/tb_kernel_load_ctrl.sv
// Bench for kernel_load_ctrl: behavioural weight memory and kernel FIFO, ack responder,
// scoreboard queues filled at stimulus time and drained by a negedge monitor.
module tb_kernel_load_ctrl;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int TAPS   = 9;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              resetn, start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  num_kernels;
  logic              busy, done, mem_rd_en, fifo_clr_n, fifo_write, fifo_read;
  logic [CNT_W-1:0]  kernel_idx;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_full, fifo_empty, kernel_valid, error;
  logic              kernel_ack = 1'b0;

  always #5 clk = ~clk;

  kernel_load_ctrl dut (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
    .num_kernels(num_kernels), .busy(busy), .done(done), .kernel_idx(kernel_idx),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .fifo_clr_n(fifo_clr_n), .fifo_write(fifo_write), .fifo_read(fifo_read),
    .fifo_data(fifo_data), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .kernel_valid(kernel_valid), .kernel_ack(kernel_ack), .error(error)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // weight memory: word at address a holds a; junk when not read
  always @(posedge clk) mem_rdata <= mem_rd_en ? DATA_W'(mem_addr) : 32'hDEAD_BEEF;

  // kernel FIFO model
  logic [DATA_W-1:0] slot [TAPS];
  logic [DATA_W-1:0] dout [TAPS];
  int  fcnt = 0;
  bit  hold_full0 = 1'b0;
  always @(posedge clk) begin
    if (!fifo_clr_n) fcnt <= 0;
    else if (fifo_write && fcnt < TAPS) begin
      slot[fcnt] <= fifo_data;
      fcnt       <= fcnt + 1;
    end
    if (fifo_read) for (int i = 0; i < TAPS; i++) dout[i] <= slot[i];
  end
  assign fifo_full  = (fcnt == TAPS) && !hold_full0;
  assign fifo_empty = (fcnt == 0);

  // ack responder: tied high, or raised after ack_delay valid cycles
  bit ack_tied = 1'b0;
  int ack_delay = 0;
  int vcnt = 0;
  always @(negedge clk) begin
    if (ack_tied) begin
      kernel_ack = 1'b1;
      vcnt = 0;
    end else if (kernel_valid) begin
      kernel_ack = (vcnt >= ack_delay);
      vcnt++;
    end else begin
      kernel_ack = 1'b0;
      vcnt = 0;
    end
  end

  int errors = 0;
  int checks = 0;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask
  task automatic fail(input string name, input logic [63:0] got);
    checks++;
    errors++;
    $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, got, cyc);
  endtask

  typedef struct {int cyc; int idx; int tap0;} kv_t;
  int  exp_addr[$];
  kv_t exp_kv[$];
  int  exp_done[$];
  int  kv_seen = 0, rd_pulses = 0;
  kv_t ek;
  logic kv_prev = 1'b0, clr_prev = 1'b1, rd_prev = 1'b0;

  always @(negedge clk) begin
    if (mem_rd_en) begin
      if (exp_addr.size() == 0) fail("spurious_mem_rd", 64'(mem_addr));
      else check("mem_addr", 64'(mem_addr), 64'(exp_addr.pop_front()));
      if (!rd_prev) check("clr_before_fetch", 64'(clr_prev), 64'(0));
    end
    if (kernel_valid && !kv_prev) begin
      if (exp_kv.size() == 0) fail("spurious_kernel_valid", 64'(kernel_idx));
      else begin
        ek = exp_kv.pop_front();
        kv_seen++;
        check("kv_cycle", 64'(cyc), 64'(ek.cyc));
        check("kv_idx", 64'(kernel_idx), 64'(ek.idx));
        for (int i = 0; i < TAPS; i++)
          check($sformatf("tap%0d", i), 64'(dout[i]), 64'((ek.tap0 + i) & 16'hFFFF));
      end
    end
    if (done) begin
      if (exp_done.size() == 0) fail("spurious_done", 64'(cyc));
      else check("done_cycle", 64'(cyc), 64'(exp_done.pop_front()));
    end
    if (fifo_write) begin
      check("write_vs_read", 64'(fifo_read), 64'(0));
      check("write_vs_full", 64'(fifo_full), 64'(0));
    end
    if (fifo_read) rd_pulses++;
    kv_prev  = kernel_valid;
    clr_prev = fifo_clr_n;
    rd_prev  = mem_rd_en;
  end

  // issue a start and push the expected response; delay = ack delay (0 when tied)
  task automatic issue(input int base, input int n, input int delay, input bit tied, input bit latches);
    int s;
    @(negedge clk);
    ack_tied    = tied;
    ack_delay   = delay;
    s           = cyc;
    base_addr   = ADDR_W'(base);
    num_kernels = CNT_W'(n);
    start       = 1'b1;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < TAPS; i++) exp_addr.push_back((base + k * TAPS + i) & 16'hFFFF);
      if (latches) exp_kv.push_back('{s + 14 + k * (15 + delay), k, base + k * TAPS});
    end
    if (!latches)    exp_done.push_back(s + 15);
    else if (n == 0) exp_done.push_back(s + 1);
    else             exp_done.push_back(s + 16 + (n - 1) * (15 + delay) + delay);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_addr.size() + exp_kv.size() + exp_done.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) fail("drain_timeout", 64'(exp_addr.size() + exp_kv.size() + exp_done.size()));
    repeat (3) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag, input logic clr_want);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_mem_rd_en"}, 64'(mem_rd_en), 64'(0));
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    check({tag, "_fifo_write"}, 64'(fifo_write), 64'(0));
    check({tag, "_fifo_read"}, 64'(fifo_read), 64'(0));
    check({tag, "_fifo_data"}, 64'(fifo_data), 64'(0));
    check({tag, "_kernel_valid"}, 64'(kernel_valid), 64'(0));
    check({tag, "_kernel_idx"}, 64'(kernel_idx), 64'(0));
    check({tag, "_error"}, 64'(error), 64'(0));
    check({tag, "_fifo_clr_n"}, 64'(fifo_clr_n), 64'(clr_want));
  endtask

  initial begin
    int n;
    resetn = 1'b0; start = 1'b0; base_addr = '0; num_kernels = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset", 1'b0);
    resetn = 1'b1;
    @(negedge clk);

    // single kernel, ack tied high
    issue(16'h0010, 1, 0, 1'b1, 1'b1);
    wait_drain(60);

    // three kernels, ack after 5 valid cycles
    issue(16'h0040, 3, 5, 1'b0, 1'b1);
    wait_drain(120);

    // zero kernels: done only, no busy
    issue(0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("zero_busy", 64'(busy), 64'(0));
      @(negedge clk);
    end
    wait_drain(10);

    // address wrap
    issue(16'hFFFC, 1, 0, 1'b0, 1'b1);
    wait_drain(60);
    check("wrap_error", 64'(error), 64'(0));

    // reset during FETCH of kernel 1, then a clean load
    issue(16'h0100, 2, 0, 1'b0, 1'b1);
    n = 0;
    while (!(mem_rd_en && kernel_idx == 1) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) fail("reset_wait_timeout", 64'(kernel_idx));
    #1;
    exp_addr.delete(); exp_kv.delete(); exp_done.delete();
    resetn = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset", 1'b0);
    resetn = 1'b1;
    issue(16'h0200, 1, 0, 1'b0, 1'b1);
    wait_drain(60);

`ifdef KLC_ERR_CHECK_EN
    // DRAIN timeout: error, done, no latch; later start ignored until reset
    hold_full0 = 1'b1;
    issue(16'h0300, 1, 0, 1'b0, 1'b0);
    wait_drain(60);
    check("tmo_error", 64'(error), 64'(1));
    check("tmo_busy", 64'(busy), 64'(0));
    @(negedge clk);
    start = 1'b1; num_kernels = 1; base_addr = 16'h0400;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("ignored_start_busy", 64'(busy), 64'(0));
    check("ignored_start_error", 64'(error), 64'(1));
    hold_full0 = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("error_cleared", 64'(error), 64'(0));
`else
    check("error_tied", 64'(error), 64'(0));
`endif

    check("queues_empty", 64'(exp_addr.size() + exp_kv.size() + exp_done.size()), 64'(0));
    check("latch_count", 64'(rd_pulses), 64'(kv_seen));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
